// File: rtl/dual_ad7528_serializer.sv
// Serial transmitter for the dual AD7528 attenuation-DAC bus: MSB-first shift, then chip-select strobe.
// Optional DAC_SHADOW_EN keeps per-DAC shadows and skips writes of unchanged values.
module dual_ad7528_serializer #(
    parameter int unsigned HALF = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_channel,
    input  logic       req_sel,
    input  logic [7:0] req_value,
    output logic       done,
    output logic       datadac,
    output logic       clkdac,
    output logic       csdac1n,
    output logic       csdac2n
);

    localparam int unsigned PW = 8;
    localparam logic [PW-1:0] PHASE_LAST = PW'(HALF - 1);
    localparam logic [PW-1:0] PHASE_DONE = PW'(HALF - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_SELECT,
        S_STROBE,
        S_RELEASE
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_phase;
    logic [2:0]    r_bit;
    logic [7:0]    r_value;
    logic          r_channel;
    logic          r_sel;
    logic          r_req_ready;
    logic          r_done;
    logic          r_datadac;
    logic          r_clkdac;
    logic          r_cs1n;
    logic          r_cs2n;

    logic w_phase_end;
    logic w_done_set;
    logic w_accept;
    logic w_skip;

    assign w_phase_end = (r_phase == PHASE_LAST);
    assign w_done_set  = (r_state == S_RELEASE) && (r_phase == PHASE_DONE);
    assign w_accept    = req_valid && r_req_ready && (r_state == S_IDLE);

`ifdef DAC_SHADOW_EN
    logic [7:0] r_shadow [4];
    logic [3:0] r_shadow_vld;
    logic [1:0] w_req_idx;
    logic [1:0] w_cur_idx;

    assign w_req_idx = {req_channel, req_sel};
    assign w_cur_idx = {r_channel, r_sel};
    assign w_skip    = r_shadow_vld[w_req_idx] && (r_shadow[w_req_idx] == req_value);

    // Shadow copy is committed only when a transfer actually completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow_vld <= '0;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_done_set) begin
            r_shadow[w_cur_idx]     <= r_value;
            r_shadow_vld[w_cur_idx] <= 1'b1;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_bit       <= '0;
            r_value     <= '0;
            r_channel   <= 1'b0;
            r_sel       <= 1'b0;
            r_req_ready <= 1'b1;
            r_done      <= 1'b0;
            r_datadac   <= 1'b0;
            r_clkdac    <= 1'b0;
            r_cs1n      <= 1'b1;
            r_cs2n      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                // Ready drops for one cycle after a skipped request
                r_req_ready <= 1'b1;
                if (w_accept) begin
                    r_value     <= req_value;
                    r_channel   <= req_channel;
                    r_sel       <= req_sel;
                    r_req_ready <= 1'b0;
                    if (w_skip) begin
                        r_done <= 1'b1;
                    end else begin
                        r_state   <= S_SHIFT_LO;
                        r_phase   <= '0;
                        r_bit     <= 3'd7;
                        r_datadac <= req_value[7];
                        r_clkdac  <= 1'b0;
                    end
                end
            end else begin
                r_phase <= r_phase + PW'(1);
                if (w_done_set) begin
                    r_done <= 1'b1;
                end
                if (w_phase_end) begin
                    r_phase <= '0;
                    case (r_state)
                        S_SHIFT_LO: begin
                            r_state  <= S_SHIFT_HI;
                            r_clkdac <= 1'b1;
                        end
                        S_SHIFT_HI: begin
                            r_clkdac <= 1'b0;
                            if (r_bit == 3'd0) begin
                                r_state   <= S_SELECT;
                                r_datadac <= r_sel;
                            end else begin
                                r_state   <= S_SHIFT_LO;
                                r_bit     <= r_bit - 3'd1;
                                r_datadac <= r_value[r_bit - 3'd1];
                            end
                        end
                        S_SELECT: begin
                            r_state <= S_STROBE;
                            r_cs1n  <= r_channel;
                            r_cs2n  <= ~r_channel;
                        end
                        S_STROBE: begin
                            r_state <= S_RELEASE;
                            r_cs1n  <= 1'b1;
                            r_cs2n  <= 1'b1;
                        end
                        S_RELEASE: begin
                            r_state     <= S_IDLE;
                            r_req_ready <= 1'b1;
                        end
                        default: begin
                            r_state <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign req_ready = r_req_ready;
    assign done      = r_done;
    assign datadac   = r_datadac;
    assign clkdac    = r_clkdac;
    assign csdac1n   = r_cs1n;
    assign csdac2n   = r_cs2n;

endmodule

// File: tb/tb_dual_ad7528_serializer.sv
// Self-checking bench: receiver/attenuator model plus protocol monitor for dual_ad7528_serializer.
module tb_dual_ad7528_serializer;

    localparam int HALF = 2;
    localparam int XFER = 19 * HALF;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_channel = 1'b0;
    logic       req_sel = 1'b0;
    logic [7:0] req_value = 8'h00;
    logic       done;
    logic       datadac;
    logic       clkdac;
    logic       csdac1n;
    logic       csdac2n;

    dual_ad7528_serializer #(.HALF(HALF)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_channel (req_channel),
        .req_sel     (req_sel),
        .req_value   (req_value),
        .done        (done),
        .datadac     (datadac),
        .clkdac      (clkdac),
        .csdac1n     (csdac1n),
        .csdac2n     (csdac2n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ch;
        logic       sel;
        logic [7:0] val;
    } req_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Receiver / reference model state
    req_t       exp_q[$];
    logic [7:0] fac [2][2];
    logic [7:0] shreg = 8'h00;
    logic [7:0] shadow [2][2];
    logic       shadow_vld [2][2];
    int acc_count = 0, last_acc = 0, done_count = 0, last_done = 0;
    int bus_changes = 0, strobe_count = 0, strobe1_count = 0, strobe2_count = 0;
    int rises_xfer = 0;
    int run_clk = 99, run_data = 99, run_cs1 = 99, run_cs2 = 99;
    logic p_clk = 1'b0, p_data = 1'b0, p_cs1 = 1'b1, p_cs2 = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and behavioural receiver, sampled on the falling edge
    always @(negedge clk) begin
        logic rise, cs1f, cs2f, skip, ch;
        req_t e;
        if (!reset_n) begin
            exp_q.delete();
            rises_xfer = 0;
            run_clk = 99; run_data = 99; run_cs1 = 99; run_cs2 = 99;
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) shadow_vld[i][j] = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                acc_count++;
                last_acc = cyc + 1;
                skip = 1'b0;
`ifdef DAC_SHADOW_EN
                skip = shadow_vld[req_channel][req_sel] && (shadow[req_channel][req_sel] == req_value);
`endif
                if (!skip) exp_q.push_back({req_channel, req_sel, req_value});
            end
            if (done) begin
                done_count++;
                last_done = cyc;
            end
            rise = clkdac && !p_clk;
            cs1f = !csdac1n && p_cs1;
            cs2f = !csdac2n && p_cs2;
            if (clkdac != p_clk || datadac != p_data || csdac1n != p_cs1 || csdac2n != p_cs2)
                bus_changes++;
            n_vec++;
            if (clkdac != p_clk && (!csdac1n || !csdac2n || !p_cs1 || !p_cs2)) begin
                n_err++;
                $display("FAIL clk_edge_under_cs: cyc=%0d cs1n=%b cs2n=%b required both 1", cyc, csdac1n, csdac2n);
            end
            n_vec++;
            if (!csdac1n && !csdac2n) begin
                n_err++;
                $display("FAIL both_cs_low: cyc=%0d got both low, required at most one", cyc);
            end
            n_vec++;
            if ((rise || cs1f || cs2f) && datadac != p_data) begin
                n_err++;
                $display("FAIL data_moves_on_edge: cyc=%0d datadac %b->%b required stable", cyc, p_data, datadac);
            end
            n_vec++;
            if ((clkdac != p_clk && run_clk < 2) || (datadac != p_data && run_data < 2) ||
                (csdac1n != p_cs1 && run_cs1 < 2) || (csdac2n != p_cs2 && run_cs2 < 2)) begin
                n_err++;
                $display("FAIL level_width: cyc=%0d runs clk=%0d data=%0d cs1=%0d cs2=%0d required >=2",
                         cyc, run_clk, run_data, run_cs1, run_cs2);
            end
            if ((csdac1n && !p_cs1) || (csdac2n && !p_cs2)) begin
                n_vec++;
                if ((!p_cs1 ? run_cs1 : run_cs2) != HALF) begin
                    n_err++;
                    $display("FAIL cs_width: got %0d required %0d", (!p_cs1 ? run_cs1 : run_cs2), HALF);
                end
            end
            if (rise) begin
                shreg = {shreg[6:0], datadac};
                rises_xfer++;
            end
            if (cs1f || cs2f) begin
                ch = cs2f;
                fac[ch][datadac] = shreg;
                strobe_count++;
                if (cs1f) strobe1_count++; else strobe2_count++;
                n_vec++;
                if (rises_xfer != 8 || run_data < HALF) begin
                    n_err++;
                    $display("FAIL strobe_setup: rises=%0d data_run=%0d required 8 and >=%0d", rises_xfer, run_data, HALF);
                end
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_strobe: got ch=%0b sel=%0b val=%02h, required none", ch, datadac, shreg);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ch !== ch || e.sel !== datadac || e.val !== shreg) begin
                        n_err++;
                        $display("FAIL strobe_content: got ch=%0b sel=%0b val=%02h required ch=%0b sel=%0b val=%02h",
                                 ch, datadac, shreg, e.ch, e.sel, e.val);
                    end
                end
                shadow[ch][datadac] = shreg;
                shadow_vld[ch][datadac] = 1'b1;
                rises_xfer = 0;
            end
            run_clk  = (clkdac  != p_clk)  ? 1 : run_clk + 1;
            run_data = (datadac != p_data) ? 1 : run_data + 1;
            run_cs1  = (csdac1n != p_cs1)  ? 1 : run_cs1 + 1;
            run_cs2  = (csdac2n != p_cs2)  ? 1 : run_cs2 + 1;
        end
        p_clk = clkdac; p_data = datadac; p_cs1 = csdac1n; p_cs2 = csdac2n;
    end

    // Drive one request, wait for acceptance and done; lat = done cycle index after acceptance
    task automatic do_req(input logic ch, input logic sel, input logic [7:0] val,
                          output int acc, output int lat);
        int a0, d0;
        a0 = acc_count;
        @(posedge clk); #1;
        req_channel = ch; req_sel = sel; req_value = val; req_valid = 1'b1;
        for (int i = 0; i < 200 && acc_count == a0; i++) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        acc = last_acc;
        lat = -1;
        if (acc_count == a0) return;
        d0 = done_count;
        for (int i = 0; i < 200 && done_count == d0; i++) begin
            @(posedge clk); #1;
        end
        if (done_count != d0) lat = last_done - acc + 1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if ({clkdac, datadac, csdac1n, csdac2n, req_ready, done} !== 6'b001110) begin
            n_err++;
            $display("FAIL reset_levels: got %b required 001110", {clkdac, datadac, csdac1n, csdac2n, req_ready, done});
        end
        reset_n = 1'b1;
        begin
            int b0 = bus_changes;
            repeat (100) @(posedge clk);
            #1;
            n_vec++;
            if (bus_changes != b0 || {clkdac, datadac, csdac1n, csdac2n, req_ready} !== 5'b00111) begin
                n_err++;
                $display("FAIL reset_idle: changes=%0d levels=%b required 0 and 00111",
                         bus_changes - b0, {clkdac, datadac, csdac1n, csdac2n, req_ready});
            end
        end
    endtask

    task automatic test_left_a;
        int acc, lat, s0;
        s0 = strobe1_count;
        do_req(1'b0, 1'b1, 8'h80, acc, lat);
        n_vec++;
        if (lat != XFER) begin
            n_err++;
            $display("FAIL left_a_latency: got %0d required %0d", lat, XFER);
        end
        n_vec++;
        if (fac[0][1] !== 8'h80 || strobe1_count != s0 + 1) begin
            n_err++;
            $display("FAIL left_a_factor: got %02h strobes=%0d required 80 and 1", fac[0][1], strobe1_count - s0);
        end
        @(posedge clk); #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_done: got %b required 1", req_ready);
        end
    endtask

    task automatic test_back_to_back;
        int a0, acc1, acc2, d0, s1;
        s1 = strobe1_count;
        a0 = acc_count;
        @(posedge clk); #1;
        req_channel = 1'b1; req_sel = 1'b0; req_value = 8'h5A; req_valid = 1'b1;
        for (int i = 0; i < 200 && acc_count == a0; i++) begin
            @(posedge clk); #1;
        end
        acc1 = last_acc;
        req_sel = 1'b1; req_value = 8'hFF;
        for (int i = 0; i < 200 && acc_count == a0 + 1; i++) begin
            @(posedge clk); #1;
        end
        acc2 = last_acc;
        req_valid = 1'b0;
        n_vec++;
        if (acc2 - acc1 != XFER + 1) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d required %0d", acc2 - acc1, XFER + 1);
        end
        d0 = done_count;
        for (int i = 0; i < 200 && (done_count - d0) < 1 + (last_done < acc2 ? 1 : 0); i++) begin
            @(posedge clk); #1;
            if (last_done >= acc2 && done_count > d0 - 1 && last_done - acc2 + 1 == XFER) break;
        end
        repeat (2) @(posedge clk); #1;
        n_vec++;
        if (fac[1][0] !== 8'h5A || fac[1][1] !== 8'hFF) begin
            n_err++;
            $display("FAIL b2b_factors: got rb=%02h ra=%02h required 5a ff", fac[1][0], fac[1][1]);
        end
        n_vec++;
        if (strobe1_count != s1) begin
            n_err++;
            $display("FAIL b2b_left_quiet: got %0d left strobes required 0", strobe1_count - s1);
        end
    endtask

    task automatic test_reset_mid;
        int a0, s0, acc, lat;
        a0 = acc_count;
        s0 = strobe_count;
        @(posedge clk); #1;
        req_channel = 1'b0; req_sel = 1'b0; req_value = 8'h33; req_valid = 1'b1;
        for (int i = 0; i < 200 && acc_count == a0; i++) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({clkdac, datadac, csdac1n, csdac2n, req_ready, done} !== 6'b001110) begin
            n_err++;
            $display("FAIL mid_reset_levels: got %b required 001110", {clkdac, datadac, csdac1n, csdac2n, req_ready, done});
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (XFER) @(posedge clk);
        #1;
        n_vec++;
        if (strobe_count != s0) begin
            n_err++;
            $display("FAIL mid_reset_no_strobe: got %0d strobes required 0", strobe_count - s0);
        end
        do_req(1'b0, 1'b0, 8'h11, acc, lat);
        n_vec++;
        if (fac[0][0] !== 8'h11 || lat != XFER) begin
            n_err++;
            $display("FAIL mid_reset_recover: got %02h lat=%0d required 11 lat=%0d", fac[0][0], lat, XFER);
        end
    endtask

`ifdef DAC_SHADOW_EN
    task automatic test_shadow;
        int acc, lat, b0;
        do_req(1'b0, 1'b1, 8'h40, acc, lat);
        n_vec++;
        if (lat != XFER || fac[0][1] !== 8'h40) begin
            n_err++;
            $display("FAIL shadow_first: lat=%0d fac=%02h required %0d 40", lat, fac[0][1], XFER);
        end
        @(posedge clk); #1;
        b0 = bus_changes;
        do_req(1'b0, 1'b1, 8'h40, acc, lat);
        n_vec++;
        if (lat != 1 || bus_changes != b0) begin
            n_err++;
            $display("FAIL shadow_skip: lat=%0d toggles=%0d required 1 and 0", lat, bus_changes - b0);
        end
        do_req(1'b0, 1'b1, 8'h41, acc, lat);
        n_vec++;
        if (lat != XFER || fac[0][1] !== 8'h41) begin
            n_err++;
            $display("FAIL shadow_change: lat=%0d fac=%02h required %0d 41", lat, fac[0][1], XFER);
        end
    endtask
`endif

    task automatic test_random;
        int a0;
        a0 = acc_count;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            if (req_valid && acc_count != a0) begin
                a0 = acc_count;
                req_valid = ($urandom_range(0, 1) == 1);
                req_channel = 1'($urandom); req_sel = 1'($urandom); req_value = 8'($urandom_range(0, 7));
            end else if (!req_valid && $urandom_range(0, 3) == 0) begin
                req_valid = 1'b1;
                req_channel = 1'($urandom); req_sel = 1'($urandom); req_value = 8'($urandom_range(0, 7));
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < 200 && !(req_ready && exp_q.size() == 0); i++) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if (exp_q.size() != 0 || acc_count == 0) begin
            n_err++;
            $display("FAIL random_drain: %0d transfers missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                fac[i][j] = 8'h00;
                shadow[i][j] = 8'h00;
                shadow_vld[i][j] = 1'b0;
            end
        test_reset;
        test_left_a;
        test_back_to_back;
        test_reset_mid;
`ifdef DAC_SHADOW_EN
        test_shadow;
`endif
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
